// File: rtl/occupancy_counter.sv
// Up/down occupancy counter with saturate/wrap boundary modes, parallel load and registered flags.
// Flags and OVF/UNF pulses are derived from the next count, so they always line up with CO.
module occupancy_counter #(
    parameter int W       = 3,
    parameter int MAX_VAL = 7,
    parameter int AE_TH   = 1,
    parameter int AF_TH   = 6
) (
    input  logic         CLK,
    input  logic         MR,
    input  logic         UP,
    input  logic         DOWN,
    input  logic         LOAD,
    input  logic [W-1:0] LD_VAL,
    input  logic         WRAP_EN,
    output logic [W-1:0] CO,
    output logic         EF,
    output logic         FF,
    output logic         AEF,
    output logic         AFF,
    output logic         OVF,
    output logic         UNF
);

    // One spare bit keeps MAX_VAL = 2^W-1 from losing its carry on increment.
    localparam logic [W:0] MAXV = (W+1)'(MAX_VAL);
    localparam logic [W:0] AEV  = (W+1)'(AE_TH);
    localparam logic [W:0] AFV  = (W+1)'(AF_TH);
    localparam logic [W:0] ZERO = '0;
    localparam logic [W:0] ONE  = (W+1)'(1);

    logic [W:0] cur;
    logic [W:0] ld_ext;
    logic [W:0] nxt;
    logic       ovf_nxt;
    logic       unf_nxt;

    assign cur    = {1'b0, CO};
    assign ld_ext = {1'b0, LD_VAL};

    always_comb begin
        nxt     = cur;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (LOAD) begin
            nxt = (ld_ext > MAXV) ? MAXV : ld_ext;
        end else if (UP && !DOWN) begin
            if (cur == MAXV) begin
                ovf_nxt = 1'b1;
                nxt     = WRAP_EN ? ZERO : cur;
            end else begin
                nxt = cur + ONE;
            end
        end else if (DOWN && !UP) begin
            if (cur == ZERO) begin
                unf_nxt = 1'b1;
                nxt     = WRAP_EN ? MAXV : cur;
            end else begin
                nxt = cur - ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            CO  <= '0;
            EF  <= 1'b1;
            FF  <= 1'b0;
            AEF <= 1'b1;
            AFF <= 1'b0;
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            CO  <= nxt[W-1:0];
            EF  <= (nxt == ZERO);
            FF  <= (nxt == MAXV);
            AEF <= (nxt <= AEV);
            AFF <= (nxt >= AFV);
            OVF <= ovf_nxt;
            UNF <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: three instances (default, clamped MAX_VAL=5, 8-bit) against a
// behavioural model; expected outputs are queued when inputs are driven and popped after the edge.
module tb_occupancy_counter;

    logic CLK = 1'b0;
    logic MR;
    always #5 CLK = ~CLK;

    logic       up_a, dn_a, ld_a, wr_a;
    logic [2:0] ldv_a, co_a;
    logic       ef_a, ff_a, aef_a, aff_a, ovf_a, unf_a;

    logic       up_b, dn_b, ld_b, wr_b;
    logic [2:0] ldv_b, co_b;
    logic       ef_b, ff_b, aef_b, aff_b, ovf_b, unf_b;

    logic       up_c, dn_c, ld_c, wr_c;
    logic [7:0] ldv_c, co_c;
    logic       ef_c, ff_c, aef_c, aff_c, ovf_c, unf_c;

    occupancy_counter #(.W(3), .MAX_VAL(7), .AE_TH(1), .AF_TH(6)) dut_a (
        .CLK(CLK), .MR(MR), .UP(up_a), .DOWN(dn_a), .LOAD(ld_a), .LD_VAL(ldv_a),
        .WRAP_EN(wr_a), .CO(co_a), .EF(ef_a), .FF(ff_a), .AEF(aef_a), .AFF(aff_a),
        .OVF(ovf_a), .UNF(unf_a));

    occupancy_counter #(.W(3), .MAX_VAL(5), .AE_TH(1), .AF_TH(4)) dut_b (
        .CLK(CLK), .MR(MR), .UP(up_b), .DOWN(dn_b), .LOAD(ld_b), .LD_VAL(ldv_b),
        .WRAP_EN(wr_b), .CO(co_b), .EF(ef_b), .FF(ff_b), .AEF(aef_b), .AFF(aff_b),
        .OVF(ovf_b), .UNF(unf_b));

    occupancy_counter #(.W(8), .MAX_VAL(200), .AE_TH(10), .AF_TH(190)) dut_c (
        .CLK(CLK), .MR(MR), .UP(up_c), .DOWN(dn_c), .LOAD(ld_c), .LD_VAL(ldv_c),
        .WRAP_EN(wr_c), .CO(co_c), .EF(ef_c), .FF(ff_c), .AEF(aef_c), .AFF(aff_c),
        .OVF(ovf_c), .UNF(unf_c));

    int checks = 0;
    int errors = 0;

    int maxv [3] = '{7, 5, 200};
    int aeth [3] = '{1, 1, 10};
    int afth [3] = '{6, 4, 190};
    int mdl_co [3] = '{0, 0, 0};

    logic [13:0] sb [$];

    // Observed vector layout: {CO[7:0], EF, FF, AEF, AFF, OVF, UNF}
    localparam logic [13:0] RST_VEC = {8'd0, 6'b101000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] observe(input int w);
        case (w)
            0:       return {5'd0, co_a, ef_a, ff_a, aef_a, aff_a, ovf_a, unf_a};
            1:       return {5'd0, co_b, ef_b, ff_b, aef_b, aff_b, ovf_b, unf_b};
            default: return {co_c, ef_c, ff_c, aef_c, aff_c, ovf_c, unf_c};
        endcase
    endfunction

    function automatic logic [13:0] expect_vec(input int w, input int co, input bit ovf, input bit unf);
        return {8'(co), co == 0, co == maxv[w], co <= aeth[w], co >= afth[w], ovf, unf};
    endfunction

    task automatic drive(input int w, input bit up, input bit dn, input bit ld, input int ldv, input bit wr);
        up_a = 0; dn_a = 0; ld_a = 0;
        up_b = 0; dn_b = 0; ld_b = 0;
        up_c = 0; dn_c = 0; ld_c = 0;
        case (w)
            0: begin up_a = up; dn_a = dn; ld_a = ld; ldv_a = 3'(ldv); wr_a = wr; end
            1: begin up_b = up; dn_b = dn; ld_b = ld; ldv_b = 3'(ldv); wr_b = wr; end
            default: begin up_c = up; dn_c = dn; ld_c = ld; ldv_c = 8'(ldv); wr_c = wr; end
        endcase
    endtask

    // Drives one request, predicts its outcome, then compares after the edge.
    task automatic step(input int w, input bit up, input bit dn, input bit ld, input int ldv,
                        input bit wr, input string tag);
        int  co;
        bit  ovf, unf;
        logic [13:0] exp;
        co  = mdl_co[w];
        ovf = 0;
        unf = 0;
        if (ld) begin
            co = (ldv > maxv[w]) ? maxv[w] : ldv;
        end else if (up && !dn) begin
            if (co == maxv[w]) begin
                ovf = 1;
                if (wr) co = 0;
            end else co = co + 1;
        end else if (dn && !up) begin
            if (co == 0) begin
                unf = 1;
                if (wr) co = maxv[w];
            end else co = co - 1;
        end
        mdl_co[w] = co;
        drive(w, up, dn, ld, ldv, wr);
        sb.push_back(expect_vec(w, co, ovf, unf));
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            chk(tag, observe(w), exp);
        end
    endtask

    initial begin
        MR = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        wr_b = 0; ldv_b = 0; wr_c = 0; ldv_c = 0;
        #2;
        chk("reset_a", observe(0), RST_VEC);
        chk("reset_b", observe(1), RST_VEC);
        chk("reset_c", observe(2), RST_VEC);
        @(negedge CLK);
        MR = 1'b0;

        // Async reset mid-cycle at CO=5, then no counting while held
        step(0, 0, 0, 1, 5, 0, "load5");
        #2 MR = 1'b1;
        #1 chk("async_reset", observe(0), RST_VEC);
        drive(0, 1, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("reset_hold", observe(0), RST_VEC);
        MR = 1'b0;
        mdl_co = '{0, 0, 0};

        // Count up in saturate mode: 1..7 then hold with OVF on edges 8 and 9
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 0, 0, 0, 0, "up_sat");
            chk("up_sat_co", co_a, (i > 7) ? 7 : i);
            chk("up_sat_ovf", ovf_a, (i >= 8));
            chk("up_sat_aef", aef_a, (i < 2));
        end

        // Count down in wrap mode from 1: 0, 7 (UNF), 6
        step(0, 0, 0, 1, 1, 1, "load1");
        step(0, 0, 1, 0, 0, 1, "dn_wrap0");
        chk("dn_wrap_ef", ef_a, 1);
        step(0, 0, 1, 0, 0, 1, "dn_wrap1");
        chk("dn_wrap_co7", co_a, 7);
        chk("dn_wrap_unf", unf_a, 1);
        step(0, 0, 1, 0, 0, 1, "dn_wrap2");
        chk("dn_wrap_co6", co_a, 6);
        chk("dn_wrap_unf_clr", unf_a, 0);

        // Underflow in saturate mode holds at 0
        step(0, 0, 0, 1, 0, 0, "load0");
        step(0, 0, 1, 0, 0, 0, "dn_sat");
        chk("dn_sat_unf", unf_a, 1);

        // Simultaneous UP/DOWN holds; LOAD wins over UP
        step(0, 0, 0, 1, 3, 0, "load3");
        step(0, 1, 1, 0, 0, 0, "updn_hold");
        chk("updn_co", co_a, 3);
        step(0, 1, 0, 1, 5, 0, "load_prio");
        chk("load_prio_co", co_a, 5);

        // Load clamp on MAX_VAL=5
        step(1, 0, 0, 1, 7, 0, "clamp");
        chk("clamp_co", co_b, 5);
        chk("clamp_ff", ff_b, 1);
        chk("clamp_ovf", ovf_b, 0);

        // 8-bit instance wraps from 200 to 0
        step(2, 0, 0, 1, 199, 1, "c_load199");
        step(2, 1, 0, 0, 0, 1, "c_up200");
        chk("c_ff", ff_c, 1);
        step(2, 1, 0, 0, 0, 1, "c_wrap0");
        chk("c_wrap_co", co_c, 0);
        chk("c_wrap_ovf", ovf_c, 1);
        chk("c_wrap_ef", ef_c, 1);

        // Random traffic across all instances
        for (int i = 0; i < 400; i++) begin
            int w;
            w = $urandom_range(0, 2);
            step(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, (w == 2) ? 255 : 7),
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
